// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with DEPTH words of storage.
// It buffers a valid/ready stream from a producer on io_write to a consumer
// on io_read. It also reports occupancy, almost-full/almost-empty flags and
// supports a synchronous flush.
//
// Every output is decoded from registered state only. Nothing passes
// combinationally from one port to the other, so the block breaks timing.
//
// Ports:
//   clock            rising-edge clock
//   reset            synchronous, active-high reset (control state only)
//   io_write_valid   producer offers io_write_bits
//   io_write_ready   FIFO can accept a word (not full)
//   io_write_bits    write data, WIDTH bits
//   io_read_valid    io_read_bits holds the head word (not empty)
//   io_read_ready    consumer takes the head word
//   io_read_bits     head-of-queue data, WIDTH bits
//   io_flush         synchronous clear of pointers and count
//   io_count         occupancy, 0..DEPTH
//   io_almost_full   io_count >= AF_LEVEL
//   io_almost_empty  io_count <= AE_LEVEL
module sync_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_write_valid,
  output logic                       io_write_ready,
  input  logic [WIDTH-1:0]           io_write_bits,
  output logic                       io_read_valid,
  input  logic                       io_read_ready,
  output logic [WIDTH-1:0]           io_read_bits,
  input  logic                       io_flush,
  output logic [$clog2(DEPTH+1)-1:0] io_count,
  output logic                       io_almost_full,
  output logic                       io_almost_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic wr_fire;
  logic rd_fire;

  // Handshake decode: both readies come from the count register only.
  assign io_write_ready  = (count_q != FULL_CNT);
  assign io_read_valid   = (count_q != '0);
  assign io_read_bits    = mem_q[rd_ptr_q];
  assign io_count        = count_q;
  assign io_almost_full  = (count_q >= AF_CNT);
  assign io_almost_empty = (count_q <= AE_CNT);

  assign wr_fire = io_write_valid & io_write_ready;
  assign rd_fire = io_read_valid & io_read_ready;

  // Next-state for pointers and occupancy. Flush overrides any fire in the
  // same cycle. The pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (io_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared. Stale words are unreachable once the count
  // is zero.
  always_ff @(posedge clock) begin
    if (wr_fire && !io_flush) begin
      mem_q[wr_ptr_q] <= io_write_bits;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed testbench for sync_fifo (DEPTH=8, WIDTH=32, AF_LEVEL=6, AE_LEVEL=2).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_sync_fifo;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_write_valid;
  logic        io_write_ready;
  logic [31:0] io_write_bits;
  logic        io_read_valid;
  logic        io_read_ready;
  logic [31:0] io_read_bits;
  logic        io_flush;
  logic [3:0]  io_count;
  logic        io_almost_full;
  logic        io_almost_empty;

  int vectors    = 0;
  int miscompares = 0;

  sync_fifo #(.WIDTH(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_write_valid (io_write_valid),
    .io_write_ready (io_write_ready),
    .io_write_bits  (io_write_bits),
    .io_read_valid  (io_read_valid),
    .io_read_ready  (io_read_ready),
    .io_read_bits   (io_read_bits),
    .io_flush       (io_flush),
    .io_count       (io_count),
    .io_almost_full (io_almost_full),
    .io_almost_empty(io_almost_empty)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    io_write_valid = 1'b0;
    io_write_bits  = '0;
    io_read_ready  = 1'b0;
    io_flush       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    tick();
    vectors++; if (io_count !== 4'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", io_count); end
    vectors++; if (io_read_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid got %b want 0", io_read_valid); end
    vectors++; if (io_write_ready !== 1'b1) begin miscompares++; $display("FAIL reset_wready got %b want 1", io_write_ready); end
    vectors++; if (io_almost_empty !== 1'b1) begin miscompares++; $display("FAIL reset_ae got %b want 1", io_almost_empty); end
    vectors++; if (io_almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_af got %b want 0", io_almost_full); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      io_write_valid = 1'b1;
      io_write_bits  = 32'(i);
      tick();
      vectors++; if (io_count !== 4'(i + 1)) begin miscompares++; $display("FAIL fill_count[%0d] got %0d want %0d", i, io_count, i + 1); end
      vectors++; if (io_almost_full !== (i + 1 >= 6)) begin miscompares++; $display("FAIL fill_af[%0d] got %b want %b", i, io_almost_full, (i + 1 >= 6)); end
      vectors++; if (io_write_ready !== (i + 1 != 8)) begin miscompares++; $display("FAIL fill_wready[%0d] got %b want %b", i, io_write_ready, (i + 1 != 8)); end
    end
    // Writes offered while full must be ignored.
    io_write_bits = 32'hBAD0_BAD0;
    tick();
    tick();
    vectors++; if (io_count !== 4'd8) begin miscompares++; $display("FAIL full_ignore_count got %0d want 8", io_count); end
    io_write_valid = 1'b0;
    io_read_ready  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      vectors++; if (io_read_bits !== 32'(k)) begin miscompares++; $display("FAIL drain_data[%0d] got %h want %h", k, io_read_bits, k); end
      vectors++; if (io_almost_empty !== (8 - k <= 2)) begin miscompares++; $display("FAIL drain_ae[%0d] got %b want %b", k, io_almost_empty, (8 - k <= 2)); end
      tick();
      vectors++; if (io_count !== 4'(7 - k)) begin miscompares++; $display("FAIL drain_count[%0d] got %0d want %0d", k, io_count, 7 - k); end
    end
    io_read_ready = 1'b0;
    vectors++; if (io_read_valid !== 1'b0) begin miscompares++; $display("FAIL drain_rvalid got %b want 0", io_read_valid); end
    vectors++; if (io_almost_empty !== 1'b1) begin miscompares++; $display("FAIL drain_ae_end got %b want 1", io_almost_empty); end
  endtask

  task automatic test_full_both();
    for (int i = 0; i < 8; i++) begin
      io_write_valid = 1'b1;
      io_write_bits  = 32'h10 + 32'(i);
      tick();
    end
    // Full: only the read may fire even though a write is offered.
    io_write_bits = 32'h0000_DEAD;
    io_read_ready = 1'b1;
    vectors++; if (io_read_bits !== 32'h10) begin miscompares++; $display("FAIL fullboth_head got %h want 10", io_read_bits); end
    tick();
    vectors++; if (io_count !== 4'd7) begin miscompares++; $display("FAIL fullboth_count got %0d want 7", io_count); end
    vectors++; if (io_write_ready !== 1'b1) begin miscompares++; $display("FAIL fullboth_wready got %b want 1", io_write_ready); end
    io_write_bits = 32'h0000_BEEF;
    vectors++; if (io_read_bits !== 32'h11) begin miscompares++; $display("FAIL both_head got %h want 11", io_read_bits); end
    tick();
    vectors++; if (io_count !== 4'd7) begin miscompares++; $display("FAIL both_count got %0d want 7", io_count); end
    io_write_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      automatic logic [31:0] exp = (k < 6) ? 32'h12 + 32'(k) : 32'h0000_BEEF;
      vectors++; if (io_read_bits !== exp) begin miscompares++; $display("FAIL fullboth_drain[%0d] got %h want %h", k, io_read_bits, exp); end
      tick();
    end
    io_read_ready = 1'b0;
    vectors++; if (io_count !== 4'd0) begin miscompares++; $display("FAIL fullboth_end_count got %0d want 0", io_count); end
  endtask

  task automatic test_wrap();
    int sent = 0;
    int recv = 0;
    int mcount = 0;
    int cycles = 0;
    bit wf, rf;
    while (recv < 100 && cycles < 3000) begin
      io_write_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
      io_write_bits  = 32'h1000 + 32'(sent);
      io_read_ready  = ($urandom_range(0, 3) != 0);
      wf = io_write_valid && (mcount != 8);
      rf = io_read_ready && (mcount != 0);
      if (rf) begin
        vectors++; if (io_read_bits !== 32'h1000 + 32'(recv)) begin miscompares++; $display("FAIL wrap_data[%0d] got %h want %h", recv, io_read_bits, 32'h1000 + 32'(recv)); end
      end
      tick();
      cycles++;
      if (wf) sent++;
      if (rf) recv++;
      mcount = sent - recv;
      vectors++; if (io_count !== 4'(mcount)) begin miscompares++; $display("FAIL wrap_count cyc %0d got %0d want %0d", cycles, io_count, mcount); end
    end
    vectors++; if (recv != 100) begin miscompares++; $display("FAIL wrap_timeout received %0d want 100", recv); end
    idle_inputs();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      io_write_valid = 1'b1;
      io_write_bits  = 32'h20 + 32'(i);
      tick();
    end
    io_write_bits = 32'hFFFF_0000;
    io_read_ready = 1'b1;
    io_flush      = 1'b1;
    tick();
    idle_inputs();
    vectors++; if (io_count !== 4'd0) begin miscompares++; $display("FAIL flush_count got %0d want 0", io_count); end
    vectors++; if (io_read_valid !== 1'b0) begin miscompares++; $display("FAIL flush_rvalid got %b want 0", io_read_valid); end
    io_write_valid = 1'b1;
    io_write_bits  = 32'hA5A5_A5A5;
    tick();
    io_write_valid = 1'b0;
    vectors++; if (io_read_bits !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL flush_first got %h want a5a5a5a5", io_read_bits); end
    vectors++; if (io_count !== 4'd1) begin miscompares++; $display("FAIL flush_after_count got %0d want 1", io_count); end
    io_read_ready = 1'b1;
    tick();
    io_read_ready = 1'b0;
    vectors++; if (io_read_valid !== 1'b0) begin miscompares++; $display("FAIL flush_end_rvalid got %b want 0", io_read_valid); end
  endtask

  task automatic test_empty_latency();
    io_write_valid = 1'b1;
    io_write_bits  = 32'h1234_5678;
    vectors++; if (io_read_valid !== 1'b0) begin miscompares++; $display("FAIL lat_before got %b want 0", io_read_valid); end
    tick();
    io_write_valid = 1'b0;
    vectors++; if (io_read_valid !== 1'b1) begin miscompares++; $display("FAIL lat_rvalid got %b want 1", io_read_valid); end
    vectors++; if (io_read_bits !== 32'h1234_5678) begin miscompares++; $display("FAIL lat_data got %h want 12345678", io_read_bits); end
    io_read_ready = 1'b1;
    tick();
    io_read_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      io_write_valid = 1'b1;
      io_write_bits  = 32'h30 + 32'(i);
      tick();
    end
    vectors++; if (io_count !== 4'd5) begin miscompares++; $display("FAIL rmid_pre_count got %0d want 5", io_count); end
    reset = 1'b1;
    io_write_bits = 32'h0000_0099;
    tick();
    reset = 1'b0;
    io_write_valid = 1'b0;
    vectors++; if (io_count !== 4'd0) begin miscompares++; $display("FAIL rmid_count got %0d want 0", io_count); end
    vectors++; if (io_read_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_rvalid got %b want 0", io_read_valid); end
    vectors++; if (io_write_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_wready got %b want 1", io_write_ready); end
    vectors++; if (io_almost_empty !== 1'b1) begin miscompares++; $display("FAIL rmid_ae got %b want 1", io_almost_empty); end
    io_write_valid = 1'b1;
    io_write_bits  = 32'h0000_0055;
    tick();
    io_write_valid = 1'b0;
    vectors++; if (io_read_bits !== 32'h0000_0055) begin miscompares++; $display("FAIL rmid_data got %h want 55", io_read_bits); end
    vectors++; if (io_count !== 4'd1) begin miscompares++; $display("FAIL rmid_after_count got %0d want 1", io_count); end
    io_read_ready = 1'b1;
    tick();
    io_read_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_both();
    test_wrap();
    test_flush();
    test_empty_latency();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
